// File: rtl/simon_autoplayer.sv
// Simon Says autoplayer: records the symbols blinked on the game LEDs and
// replays them as timed one-hot presses on the switch bus.
module simon_autoplayer #(
    parameter int DEBOUNCE     = 4,
    parameter int IDLE_CYCLES  = 2_000_000,
    parameter int PRESS_CYCLES = 500_000,
    parameter int GAP_CYCLES   = 500_000,
    parameter int DEPTH        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] led_in,
    output logic [9:0] sw_out,
    output logic       busy,
    output logic       replaying,
    output logic       replay_done,
    output logic [4:0] seq_len,
    output logic       overflow
);

    localparam int PH_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int STAB_W = $clog2(DEBOUNCE + 1);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(DEBOUNCE - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [PH_W-1:0]   PRESS_LAST = PH_W'(PRESS_CYCLES - 1);
    localparam logic [PH_W-1:0]   GAP_LAST   = PH_W'(GAP_CYCLES - 1);
    localparam logic [4:0]        SEQ_FULL   = 5'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LISTEN, S_ARMED, S_HELD, S_PRESS, S_GAP, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        sync1_q, sync2_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [1:0]        armed_q, armed_d;
    logic [4:0]        seq_len_q, seq_len_d;
    logic              overflow_q, overflow_d;
    logic [9:0]        sw_out_q, sw_out_d;
    logic              busy_q, busy_d, replaying_q, replaying_d, done_q, done_d;
    logic              wr_en;
    logic [1:0]        mem_q [DEPTH];

    logic       sym_dark, sym_valid;
    logic [1:0] sym_idx;

    always_comb begin
        sym_dark  = (sync2_q == '0);
        sym_valid = (sync2_q[9:4] == '0) && $onehot(sync2_q[3:0]);
        sym_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i]) sym_idx = 2'(i);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        stab_d     = stab_q;
        idle_d     = idle_q;
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        armed_d    = armed_q;
        seq_len_d  = seq_len_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;

        unique case (state_q)
            S_IDLE: if (enable) state_d = S_LISTEN;
            S_LISTEN: begin
                if (!sym_dark) idle_d = '0;
                if (sym_valid) begin
                    armed_d = sym_idx;
                    stab_d  = STAB_W'(1);
                    state_d = S_ARMED;
                end else if (sym_dark && seq_len_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        idle_d  = '0;
                        ptr_d   = '0;
                        phase_d = '0;
                        state_d = S_PRESS;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            S_ARMED: begin
                if (sym_valid && sym_idx == armed_q) begin
                    if (stab_q == STAB_LAST) begin
                        stab_d  = '0;
                        state_d = S_HELD;
                        if (seq_len_q == SEQ_FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en     = 1'b1;
                            seq_len_d = seq_len_q + 5'd1;
                        end
                    end else begin
                        stab_d = stab_q + STAB_W'(1);
                    end
                end else begin
                    stab_d  = '0;
                    state_d = S_LISTEN;
                end
            end
            S_HELD: if (sym_dark) state_d = S_LISTEN;
            S_PRESS: begin
                if (phase_q == PRESS_LAST) begin
                    phase_d = '0;
                    state_d = S_GAP;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_GAP: begin
                if (phase_q == GAP_LAST) begin
                    phase_d = '0;
                    // Compare in 5 bits so a full 16-entry buffer terminates cleanly.
                    if ({1'b0, ptr_q} + 5'd1 == seq_len_q) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = S_PRESS;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_DONE: begin
                seq_len_d = '0;
                state_d   = S_LISTEN;
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) state_d = S_IDLE;
        if (state_d == S_IDLE) begin
            seq_len_d  = '0;
            overflow_d = 1'b0;
            stab_d     = '0;
            idle_d     = '0;
            phase_d    = '0;
            ptr_d      = '0;
            wr_en      = 1'b0;
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        sw_out_d = '0;
        if (state_d == S_PRESS) sw_out_d[3:0] = 4'b0001 << mem_q[ptr_d];
        busy_d      = !(state_d == S_IDLE || (state_d == S_LISTEN && seq_len_d == '0));
        replaying_d = (state_d == S_PRESS) || (state_d == S_GAP);
        done_d      = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            stab_q      <= '0;
            idle_q      <= '0;
            phase_q     <= '0;
            ptr_q       <= '0;
            armed_q     <= '0;
            seq_len_q   <= '0;
            overflow_q  <= 1'b0;
            sw_out_q    <= '0;
            busy_q      <= 1'b0;
            replaying_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= led_in;
            sync2_q     <= sync1_q;
            stab_q      <= stab_d;
            idle_q      <= idle_d;
            phase_q     <= phase_d;
            ptr_q       <= ptr_d;
            armed_q     <= armed_d;
            seq_len_q   <= seq_len_d;
            overflow_q  <= overflow_d;
            sw_out_q    <= sw_out_d;
            busy_q      <= busy_d;
            replaying_q <= replaying_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the symbol buffer is deliberately not reset; seq_len alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[seq_len_q[PTR_W-1:0]] <= armed_q;
    end

    assign sw_out      = sw_out_q;
    assign busy        = busy_q;
    assign replaying   = replaying_q;
    assign replay_done = done_q;
    assign seq_len     = seq_len_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Bench for simon_autoplayer: directed and random blink sequences checked
// against a queue-based model of what should be recorded and replayed.
module tb_simon_autoplayer;

    localparam int DEB     = 4;
    localparam int IDLE_C  = 20;
    localparam int PRESS_C = 8;
    localparam int GAP_C   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] led_in;
    logic [9:0] sw_out;
    logic       busy, replaying, replay_done, overflow;
    logic [4:0] seq_len;

    int checks = 0;
    int errors = 0;

    // Reference model: symbols expected in the buffer, and the expected sticky overflow.
    logic [1:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    simon_autoplayer #(
        .DEBOUNCE(DEB), .IDLE_CYCLES(IDLE_C), .PRESS_CYCLES(PRESS_C),
        .GAP_CYCLES(GAP_C), .DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .led_in(led_in),
        .sw_out(sw_out), .busy(busy), .replaying(replaying),
        .replay_done(replay_done), .seq_len(seq_len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [9:0] v, input int n);
        led_in = v;
        repeat (n) @(negedge clk);
    endtask

    // A blink is recorded iff it stays lit for at least DEB cycles; beyond 16 it only sets overflow.
    task automatic blink(input logic [1:0] s, input int lit, input int dark);
        logic [9:0] v;
        v = 10'd1 << s;
        drive(v, lit);
        drive('0, dark);
        if (lit >= DEB) begin
            if (exp_q.size() < 16) exp_q.push_back(s);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic check_replay();
        int t, len;
        logic [9:0] v, want;
        t = 0;
        while (sw_out == '0 && t < IDLE_C + 10) begin
            @(negedge clk);
            t++;
        end
        check("replay_start_window", 32'(t >= IDLE_C - 5 && t < IDLE_C + 10), 32'd1);
        if (sw_out == '0) return;
        for (int i = 0; i < exp_q.size(); i++) begin
            v    = sw_out;
            want = 10'd1 << exp_q[i];
            check("press_value", 32'(v), 32'(want));
            check("replaying_in_press", 32'(replaying), 32'd1);
            len = 0;
            while (sw_out == v && len < PRESS_C + 4) begin
                @(negedge clk);
                len++;
            end
            check("press_length", 32'(len), 32'(PRESS_C));
            len = 0;
            while (sw_out == '0 && !replay_done && len < GAP_C + 4) begin
                @(negedge clk);
                len++;
            end
            check("gap_length", 32'(len), 32'(GAP_C));
            check("replay_done_timing", 32'(replay_done), 32'(i == exp_q.size() - 1));
        end
        @(negedge clk);
        check("replay_done_one_cycle", 32'(replay_done), 32'd0);
        check("seq_len_cleared", 32'(seq_len), 32'd0);
        check("overflow_after_replay", 32'(overflow), 32'(exp_ovf));
        check("sw_out_after_replay", 32'(sw_out), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n, t;
        logic seen;
        logic [1:0] s;

        reset  = 1'b0;
        enable = 1'b0;
        led_in = '0;
        repeat (3) @(negedge clk);
        check("reset_sw_out", 32'(sw_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_replaying", 32'(replaying), 32'd0);
        check("reset_replay_done", 32'(replay_done), 32'd0);
        check("reset_seq_len", 32'(seq_len), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Single symbol
        blink(2'd2, 10, 5);
        check("single_seq_len", 32'(seq_len), 32'(exp_q.size()));
        check("single_busy", 32'(busy), 32'd1);
        check_replay();

        // Sequence 2,0,3,3
        blink(2'd2, 10, 5);
        blink(2'd0, 10, 5);
        blink(2'd3, 10, 5);
        blink(2'd3, 10, 5);
        check("seq4_seq_len", 32'(seq_len), 32'd4);
        check_replay();

        // Glitches: too short, junk pattern, upper-bit pattern
        drive(10'h002, 3);
        drive('0, 5);
        drive(10'h003, 10);
        drive('0, 5);
        drive(10'h010, 10);
        drive('0, 5);
        check("glitch_seq_len", 32'(seq_len), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (IDLE_C + 10) begin
            @(negedge clk);
            if (sw_out != '0) seen = 1'b1;
        end
        check("glitch_no_replay", 32'(seen), 32'd0);

        // Random rounds with interleaved too-short blinks
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                s = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) blink(s, $urandom_range(1, DEB - 1), $urandom_range(3, 8));
                s = 2'($urandom_range(0, 3));
                blink(s, $urandom_range(DEB, 12), (k == n - 1) ? 5 : $urandom_range(3, 8));
            end
            check("random_seq_len", 32'(seq_len), 32'(exp_q.size()));
            check_replay();
        end

        // Overflow: 17 accepted blinks
        for (int k = 0; k < 17; k++) blink(2'($urandom_range(0, 3)), 6, (k == 16) ? 5 : 4);
        check("ovf_seq_len", 32'(seq_len), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check_replay();

        // enable dropped in the middle of the second press
        for (int k = 0; k < 4; k++) blink(2'($urandom_range(0, 3)), 7, (k == 3) ? 5 : 4);
        t = 0;
        while (sw_out == '0 && t < IDLE_C + 10) begin
            @(negedge clk);
            t++;
        end
        repeat (PRESS_C + GAP_C + 3) @(negedge clk);
        check("second_press_value", 32'(sw_out), 32'(10'd1 << exp_q[1]));
        enable = 1'b0;
        @(negedge clk);
        check("disable_sw_out", 32'(sw_out), 32'd0);
        check("disable_busy", 32'(busy), 32'd0);
        check("disable_replaying", 32'(replaying), 32'd0);
        seen = replay_done;
        repeat (IDLE_C) begin
            @(negedge clk);
            if (replay_done) seen = 1'b1;
        end
        check("disable_no_done", 32'(seen), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_ovf = 1'b0;
        check("reenable_seq_len", 32'(seq_len), 32'd0);
        check("reenable_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset in the middle of a press
        blink(2'd1, 6, 5);
        t = 0;
        while (sw_out == '0 && t < IDLE_C + 10) begin
            @(negedge clk);
            t++;
        end
        check("pre_reset_press", 32'(sw_out), 32'h002);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_sw_out", 32'(sw_out), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_replaying", 32'(replaying), 32'd0);
        check("async_reset_seq_len", 32'(seq_len), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("post_reset_sw_out", 32'(sw_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
